// File: rtl/reduct_gather.sv
// Serial-to-parallel packer feeding the reduct tree: gathers up to IN words into a
// padded bundle. Optional out_mask port enabled by defining REDUCT_GATHER_MASK_EN.
module reduct_gather #(
  parameter string OPE  = "or",
  parameter int    IN   = 4,
  parameter int    DATA = 16,
  localparam int   CNTW = $clog2(IN + 1)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA-1:0]          in_data,
  input  logic                     in_last,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN-1:0][DATA-1:0]  out_data,
`ifdef REDUCT_GATHER_MASK_EN
  output logic [IN-1:0]            out_mask,
`endif
  output logic [CNTW-1:0]          out_cnt
);

  // Identity element of the downstream reduction, so padding never changes the result.
  localparam logic [DATA-1:0] PAD = (OPE == "and") ? {DATA{1'b1}} : {DATA{1'b0}};

  typedef enum logic {FILL, FULL} state_t;

  state_t                    state, next_state;
  logic [IN-1:0][DATA-1:0]   slots, merged_slots;
  logic [CNTW-1:0]           fill, merged_cnt;
  logic [IN-1:0]             merged_mask;
  logic                      accept, close_now, load_out, drop_valid;

  assign in_ready = (state == FILL) || out_ready;
  assign accept   = in_valid && in_ready;

  // The working buffer is always padded and fill is zero while FULL, so a word
  // accepted during the hand-off naturally lands in slot 0.
  always_comb begin
    merged_cnt = fill + {{(CNTW-1){1'b0}}, accept};
    for (int k = 0; k < IN; k++) begin
      merged_slots[k] = (accept && (fill == CNTW'(k))) ? in_data : slots[k];
      merged_mask[k]  = CNTW'(k) < merged_cnt;
    end
    close_now = (accept && (in_last || (merged_cnt == CNTW'(IN)) || (flush && state == FILL)))
             || (!accept && flush && (state == FILL) && (fill != '0));
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= FILL;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    drop_valid = 1'b0;
    case (state)
      FILL: begin
        if (close_now) begin
          next_state = FULL;
          load_out   = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (close_now) begin
            load_out = 1'b1;
          end else begin
            next_state = FILL;
            drop_valid = 1'b1;
          end
        end
      end
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      slots <= {IN{PAD}};
      fill  <= '0;
    end else if (load_out) begin
      slots <= {IN{PAD}};
      fill  <= '0;
    end else if (accept) begin
      slots <= merged_slots;
      fill  <= merged_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid <= 1'b0;
      out_data  <= {IN{PAD}};
      out_cnt   <= '0;
`ifdef REDUCT_GATHER_MASK_EN
      out_mask  <= '0;
`endif
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= merged_slots;
      out_cnt   <= merged_cnt;
`ifdef REDUCT_GATHER_MASK_EN
      out_mask  <= merged_mask;
`endif
    end else if (drop_valid) begin
      out_valid <= 1'b0;
    end
  end

`ifndef REDUCT_GATHER_MASK_EN
  logic unused_mask;
  assign unused_mask = ^merged_mask;
`endif

endmodule
